// File: rtl/tlb_miss_ptw_arbiter.sv
// tlb_miss_ptw_arbiter
// Shares one Sv32 page-table walker between the ITLB and the DTLB. It grants
// one miss at a time with round-robin fairness, sequences the PTW request and
// response handshake, and aborts walks that stay silent for too long. The
// resulting PTE or fault is routed back to the TLB that owns the walk.
module tlb_miss_ptw_arbiter #(
   parameter int VPN_WIDTH      = 20,
   parameter int PTE_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 itlb_req_valid_i,
   input  logic [VPN_WIDTH-1:0] itlb_vpn_i,
   output logic                 itlb_req_ready_o,
   input  logic                 dtlb_req_valid_i,
   input  logic [VPN_WIDTH-1:0] dtlb_vpn_i,
   input  logic                 dtlb_is_store_i,
   output logic                 dtlb_req_ready_o,
   output logic                 ptw_req_valid_o,
   input  logic                 ptw_req_ready_i,
   output logic [VPN_WIDTH-1:0] ptw_vpn_o,
   output logic                 ptw_is_instr_o,
   output logic                 ptw_is_store_o,
   input  logic                 ptw_resp_valid_i,
   input  logic [PTE_WIDTH-1:0] ptw_pte_i,
   input  logic                 ptw_error_i,
   output logic                 ptw_abort_o,
   output logic                 itlb_resp_valid_o,
   output logic                 dtlb_resp_valid_o,
   output logic [PTE_WIDTH-1:0] resp_pte_o,
   output logic                 resp_error_o,
   output logic                 busy_o
);

   // A zero timeout still gets a one-bit counter so the vector stays legal.
   localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                 state_q, state_d;
   logic [VPN_WIDTH-1:0]   vpn_q, vpn_d;
   logic                   instr_q, instr_d;
   logic                   store_q, store_d;
   logic                   last_instr_q, last_instr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PTE_WIDTH-1:0]   pte_q, pte_d;
   logic                   err_q, err_d;

   logic                   grant_instr;
   logic                   accept;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   timeout_hit;
   logic                   abort;
   logic                   itlb_resp;
   logic                   dtlb_resp;

   // On a tie the requester that did not win last time gets the walker.
   assign grant_instr = itlb_req_valid_i && (!dtlb_req_valid_i || !last_instr_q);
   assign accept      = (state_q == ST_IDLE) && !flush_i && (itlb_req_valid_i || dtlb_req_valid_i);

   // Saturating wait counter; the walk expires on the cycle it reaches the limit.
   assign cnt_inc     = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);

   // Next-state and per-cycle strobes for the walk sequencer.
   // NOTE: every signal written here is given a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      vpn_d        = vpn_q;
      instr_d      = instr_q;
      store_d      = store_q;
      last_instr_d = last_instr_q;
      cnt_d        = cnt_q;
      pte_d        = pte_q;
      err_d        = err_q;
      abort        = 1'b0;
      itlb_resp    = 1'b0;
      dtlb_resp    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               vpn_d        = grant_instr ? itlb_vpn_i : dtlb_vpn_i;
               instr_d      = grant_instr;
               store_d      = !grant_instr && dtlb_is_store_i;
               last_instr_d = grant_instr;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (flush_i) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else if (ptw_req_ready_i) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            if (flush_i) begin
               // A response in the same cycle means the PTW is already done,
               // so only a silent walk needs the abort.
               abort   = !ptw_resp_valid_i;
               state_d = ST_IDLE;
            end else if (ptw_resp_valid_i) begin
               pte_d   = ptw_pte_i;
               err_d   = ptw_error_i;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               abort   = 1'b1;
               pte_d   = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            itlb_resp = !flush_i && instr_q;
            dtlb_resp = !flush_i && !instr_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and walk registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         vpn_q        <= '0;
         instr_q      <= 1'b0;
         store_q      <= 1'b0;
         last_instr_q <= 1'b1;
         cnt_q        <= '0;
         pte_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         vpn_q        <= vpn_d;
         instr_q      <= instr_d;
         store_q      <= store_d;
         last_instr_q <= last_instr_d;
         cnt_q        <= cnt_d;
         pte_q        <= pte_d;
         err_q        <= err_d;
      end
   end

   // Every output is forced low while reset is held, even in the first reset
   // cycle when the registers still hold the old walk.
   assign itlb_req_ready_o  = !rst_i && accept && grant_instr;
   assign dtlb_req_ready_o  = !rst_i && accept && !grant_instr;
   assign ptw_req_valid_o   = !rst_i && (state_q == ST_ISSUE);
   assign ptw_vpn_o         = rst_i ? '0 : vpn_q;
   assign ptw_is_instr_o    = !rst_i && instr_q;
   assign ptw_is_store_o    = !rst_i && store_q;
   assign ptw_abort_o       = !rst_i && abort;
   assign itlb_resp_valid_o = !rst_i && itlb_resp;
   assign dtlb_resp_valid_o = !rst_i && dtlb_resp;
   assign resp_pte_o        = rst_i ? '0 : pte_q;
   assign resp_error_o      = !rst_i && err_q;
   assign busy_o            = !rst_i && (state_q != ST_IDLE);

endmodule

// File: tb/tb_tlb_miss_ptw_arbiter.sv
// Self-checking bench for tlb_miss_ptw_arbiter. A walk-level model predicts
// every output each cycle; directed scenarios add literal expectations on
// grant order, routing, abort timing and latency.
module tb_tlb_miss_ptw_arbiter;

   localparam int VPN_W = 20;
   localparam int PTE_W = 32;
   localparam int TO    = 4;

   logic             clk;
   logic             rst_i, flush_i;
   logic             itlb_req_valid_i, dtlb_req_valid_i, dtlb_is_store_i;
   logic [VPN_W-1:0] itlb_vpn_i, dtlb_vpn_i;
   logic             itlb_req_ready_o, dtlb_req_ready_o;
   logic             ptw_req_valid_o, ptw_req_ready_i;
   logic [VPN_W-1:0] ptw_vpn_o;
   logic             ptw_is_instr_o, ptw_is_store_o;
   logic             ptw_resp_valid_i, ptw_error_i;
   logic [PTE_W-1:0] ptw_pte_i;
   logic             ptw_abort_o, itlb_resp_valid_o, dtlb_resp_valid_o;
   logic [PTE_W-1:0] resp_pte_o;
   logic             resp_error_o, busy_o;

   tlb_miss_ptw_arbiter #(
      .VPN_WIDTH(VPN_W), .PTE_WIDTH(PTE_W), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .itlb_req_valid_i(itlb_req_valid_i), .itlb_vpn_i(itlb_vpn_i),
      .itlb_req_ready_o(itlb_req_ready_o),
      .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_vpn_i(dtlb_vpn_i),
      .dtlb_is_store_i(dtlb_is_store_i), .dtlb_req_ready_o(dtlb_req_ready_o),
      .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
      .ptw_vpn_o(ptw_vpn_o), .ptw_is_instr_o(ptw_is_instr_o),
      .ptw_is_store_o(ptw_is_store_o), .ptw_resp_valid_i(ptw_resp_valid_i),
      .ptw_pte_i(ptw_pte_i), .ptw_error_i(ptw_error_i), .ptw_abort_o(ptw_abort_o),
      .itlb_resp_valid_o(itlb_resp_valid_o), .dtlb_resp_valid_o(dtlb_resp_valid_o),
      .resp_pte_o(resp_pte_o), .resp_error_o(resp_error_o), .busy_o(busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Observed walk events, stamped with the cycle they appeared in.
   typedef struct { bit instr; logic [PTE_W-1:0] pte; logic err; int cyc; } resp_rec_t;
   typedef struct { bit instr; logic [VPN_W-1:0] vpn; int cyc; } acc_rec_t;
   resp_rec_t        resp_q[$];
   acc_rec_t         acc_q[$];
   resp_rec_t        rr;
   acc_rec_t         ar;
   int               abort_cnt = 0;
   int               abort_cyc = 0;
   bit               i_acc_prev, d_acc_prev, hs_prev;
   logic [VPN_W-1:0] hs_vpn;
   bit               hs_instr, hs_store;

   // Walk-level model: one walk at most, tracked as "handed to PTW or not",
   // how many cycles the PTW has been silent, and a pending reply.
   bit               m_pending, m_walking, m_reply, m_owner_i, m_store, m_last_i;
   bit               m_err;
   int               m_waits;
   logic [VPN_W-1:0] m_vpn;
   logic [PTE_W-1:0] m_pte;
   bit               e_idle, e_win_i, e_iready, e_dready, e_abort, e_ir, e_dr;

   // Compare every output against the model, log events, then advance the model.
   always @(negedge clk) begin
      cyc++;
      if (rst_i) begin
         check("reset_outputs",
               {itlb_req_ready_o, dtlb_req_ready_o, ptw_req_valid_o, ptw_vpn_o,
                ptw_is_instr_o, ptw_is_store_o, ptw_abort_o, itlb_resp_valid_o,
                dtlb_resp_valid_o, resp_pte_o, resp_error_o, busy_o}, 64'd0);
         m_pending = 0; m_walking = 0; m_reply = 0; m_last_i = 1;
         m_waits = 0;
      end else begin
         e_idle   = !m_pending && !m_walking && !m_reply;
         e_win_i  = itlb_req_valid_i && (!dtlb_req_valid_i || !m_last_i);
         e_iready = e_idle && !flush_i && e_win_i;
         e_dready = e_idle && !flush_i && dtlb_req_valid_i && !e_win_i;
         e_abort  = (m_pending && flush_i) ||
                    (m_walking && !ptw_resp_valid_i && (flush_i || (m_waits + 1 == TO)));
         e_ir     = m_reply && !flush_i && m_owner_i;
         e_dr     = m_reply && !flush_i && !m_owner_i;

         check("req_handshake", {itlb_req_ready_o, dtlb_req_ready_o, ptw_req_valid_o},
               {e_iready, e_dready, m_pending});
         check("ptw_abort", ptw_abort_o, e_abort);
         check("resp_valid", {itlb_resp_valid_o, dtlb_resp_valid_o}, {e_ir, e_dr});
         check("busy", busy_o, !e_idle);
         if (m_pending)
            check("ptw_req_fields", {ptw_vpn_o, ptw_is_instr_o, ptw_is_store_o},
                  {m_vpn, m_owner_i, m_store});
         if (e_ir || e_dr)
            check("resp_data", {resp_pte_o, resp_error_o}, {m_pte, m_err});

         if (e_idle && (e_iready || e_dready)) begin
            m_pending = 1;
            m_owner_i = e_iready;
            m_vpn     = e_iready ? itlb_vpn_i : dtlb_vpn_i;
            m_store   = e_dready && dtlb_is_store_i;
            m_last_i  = e_iready;
         end else if (m_pending) begin
            if (flush_i) m_pending = 0;
            else if (ptw_req_ready_i) begin
               m_pending = 0; m_walking = 1; m_waits = 0;
            end
         end else if (m_walking) begin
            m_waits++;
            if (flush_i) m_walking = 0;
            else if (ptw_resp_valid_i) begin
               m_walking = 0; m_reply = 1; m_pte = ptw_pte_i; m_err = ptw_error_i;
            end else if (m_waits == TO) begin
               m_walking = 0; m_reply = 1; m_pte = '0; m_err = 1;
            end
         end else if (m_reply) begin
            m_reply = 0;
         end
      end

      i_acc_prev = itlb_req_valid_i && itlb_req_ready_o;
      d_acc_prev = dtlb_req_valid_i && dtlb_req_ready_o;
      hs_prev    = ptw_req_valid_o && ptw_req_ready_i;
      if (hs_prev) begin
         hs_vpn = ptw_vpn_o; hs_instr = ptw_is_instr_o; hs_store = ptw_is_store_o;
      end
      if (i_acc_prev || d_acc_prev) begin
         ar.instr = i_acc_prev;
         ar.vpn   = i_acc_prev ? itlb_vpn_i : dtlb_vpn_i;
         ar.cyc   = cyc;
         acc_q.push_back(ar);
      end
      if (itlb_resp_valid_o || dtlb_resp_valid_o) begin
         rr.instr = itlb_resp_valid_o;
         rr.pte   = resp_pte_o;
         rr.err   = resp_error_o;
         rr.cyc   = cyc;
         resp_q.push_back(rr);
      end
      if (ptw_abort_o) begin
         abort_cnt++;
         abort_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Literal expectations for one walk: reply count, abort count, owner,
   // data and accept-to-reply latency.
   task automatic check_walk(input string name, input int rb, input int ab0, input int exp_ab,
                             input bit exp_instr, input logic [PTE_W-1:0] exp_pte,
                             input bit exp_err, input int exp_lat);
      resp_rec_t r;
      acc_rec_t  a;
      check({name, "_resp_count"}, resp_q.size() - rb, 1);
      check({name, "_abort_count"}, abort_cnt - ab0, exp_ab);
      if (resp_q.size() > rb && acc_q.size() > 0) begin
         r = resp_q[rb];
         a = acc_q[acc_q.size() - 1];
         check({name, "_owner"}, r.instr, exp_instr);
         check({name, "_pte_err"}, {r.pte, r.err}, {exp_pte, exp_err});
         check({name, "_latency"}, r.cyc - a.cyc, exp_lat);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, want fewer", cyc);
      $fatal(1);
   end

   int rb, ab0;
   logic [PTE_W-1:0] exp_pte [3];
   bit               exp_own [3];

   initial begin
      rst_i = 1; flush_i = 0;
      itlb_req_valid_i = 0; itlb_vpn_i = '0;
      dtlb_req_valid_i = 0; dtlb_vpn_i = '0; dtlb_is_store_i = 0;
      ptw_req_ready_i = 0; ptw_resp_valid_i = 0; ptw_pte_i = '0; ptw_error_i = 0;
      repeat (3) step();
      rst_i = 0;
      step();

      // Both TLBs miss continuously: grants go D, I, D after reset.
      rb = resp_q.size();
      itlb_vpn_i = 20'h1A000; dtlb_vpn_i = 20'h0D000; dtlb_is_store_i = 1;
      itlb_req_valid_i = 1; dtlb_req_valid_i = 1; ptw_req_ready_i = 1;
      for (int c = 0; c < 40 && resp_q.size() - rb < 3; c++) begin
         if (i_acc_prev) itlb_vpn_i = itlb_vpn_i + 1'b1;
         if (d_acc_prev) dtlb_vpn_i = dtlb_vpn_i + 1'b1;
         ptw_resp_valid_i = hs_prev;
         ptw_pte_i        = {hs_vpn, 12'h0CF};
         step();
      end
      itlb_req_valid_i = 0; dtlb_req_valid_i = 0; ptw_resp_valid_i = 0;
      step();
      exp_own = '{1'b0, 1'b1, 1'b0};
      exp_pte = '{32'h0D00_00CF, 32'h1A00_00CF, 32'h0D00_10CF};
      check("rr_resp_count", resp_q.size() - rb, 3);
      if (resp_q.size() - rb >= 3)
         for (int k = 0; k < 3; k++)
            check($sformatf("rr_walk%0d", k), {resp_q[rb+k].instr, resp_q[rb+k].pte, resp_q[rb+k].err},
                  {exp_own[k], exp_pte[k], 1'b0});

      // Single DTLB store miss, response on the 4th WAIT cycle (no timeout).
      rb = resp_q.size(); ab0 = abort_cnt;
      dtlb_vpn_i = 20'h12345; dtlb_is_store_i = 1; dtlb_req_valid_i = 1; ptw_req_ready_i = 1;
      step();
      dtlb_req_valid_i = 0;
      step();
      repeat (3) step();
      ptw_resp_valid_i = 1; ptw_pte_i = 32'h2000_00CF; ptw_error_i = 0;
      step();
      ptw_resp_valid_i = 0;
      repeat (2) step();
      check("single_ptw_req", {hs_vpn, hs_instr, hs_store}, {20'h12345, 1'b0, 1'b1});
      check_walk("single", rb, ab0, 0, 1'b0, 32'h2000_00CF, 1'b0, 6);

      // Flush on the second WAIT cycle, then a stale PTW response.
      rb = resp_q.size(); ab0 = abort_cnt;
      itlb_vpn_i = 20'h00ABC; itlb_req_valid_i = 1;
      step();
      itlb_req_valid_i = 0;
      step();
      step();
      flush_i = 1;
      step();
      flush_i = 0; ptw_resp_valid_i = 1; ptw_pte_i = 32'hDEAD_BEEF;
      step();
      ptw_resp_valid_i = 0;
      repeat (2) step();
      check("flush_wait_abort_count", abort_cnt - ab0, 1);
      check("flush_wait_resp_count", resp_q.size() - rb, 0);
      if (acc_q.size() > 0)
         check("flush_wait_abort_cycle", abort_cyc - acc_q[acc_q.size()-1].cyc, 3);

      // Silent PTW: timeout after 4 WAIT cycles, error reply to the ITLB.
      rb = resp_q.size(); ab0 = abort_cnt;
      itlb_vpn_i = 20'h00777; itlb_req_valid_i = 1;
      step();
      itlb_req_valid_i = 0;
      repeat (7) step();
      check_walk("timeout", rb, ab0, 1, 1'b1, 32'h0, 1'b1, 6);
      if (acc_q.size() > 0)
         check("timeout_abort_cycle", abort_cyc - acc_q[acc_q.size()-1].cyc, 5);

      // Response on exactly the 4th WAIT cycle beats the timeout.
      rb = resp_q.size(); ab0 = abort_cnt;
      dtlb_vpn_i = 20'h00888; dtlb_is_store_i = 0; dtlb_req_valid_i = 1;
      step();
      dtlb_req_valid_i = 0;
      repeat (4) step();
      ptw_resp_valid_i = 1; ptw_pte_i = 32'h1234_5001;
      step();
      ptw_resp_valid_i = 0;
      repeat (2) step();
      check_walk("edge_resp", rb, ab0, 0, 1'b0, 32'h1234_5001, 1'b0, 6);

      // PTW stalls ready for 10 cycles; stall does not count toward timeout.
      rb = resp_q.size(); ab0 = abort_cnt;
      dtlb_vpn_i = 20'h0FEDC; dtlb_is_store_i = 1; dtlb_req_valid_i = 1; ptw_req_ready_i = 0;
      step();
      dtlb_req_valid_i = 0; dtlb_vpn_i = '0; dtlb_is_store_i = 0;
      repeat (10) step();
      ptw_req_ready_i = 1;
      step();
      repeat (2) step();
      ptw_resp_valid_i = 1; ptw_pte_i = 32'h0000_0055; ptw_error_i = 1;
      step();
      ptw_resp_valid_i = 0; ptw_error_i = 0;
      repeat (2) step();
      check("stall_ptw_req", {hs_vpn, hs_instr, hs_store}, {20'h0FEDC, 1'b0, 1'b1});
      check_walk("stall", rb, ab0, 0, 1'b0, 32'h0000_0055, 1'b1, 15);

      // Flush while still in ISSUE.
      rb = resp_q.size(); ab0 = abort_cnt;
      itlb_vpn_i = 20'h00321; itlb_req_valid_i = 1; ptw_req_ready_i = 0;
      step();
      itlb_req_valid_i = 0;
      repeat (2) step();
      flush_i = 1;
      step();
      flush_i = 0; ptw_req_ready_i = 1;
      repeat (2) step();
      check("flush_issue_abort_count", abort_cnt - ab0, 1);
      check("flush_issue_resp_count", resp_q.size() - rb, 0);
      if (acc_q.size() > 0)
         check("flush_issue_abort_cycle", abort_cyc - acc_q[acc_q.size()-1].cyc, 3);

      // Reset in WAIT with both valids high; first grant afterwards is the DTLB.
      rb = resp_q.size(); ab0 = abort_cnt;
      dtlb_vpn_i = 20'h0AAAA; dtlb_req_valid_i = 1;
      step();
      dtlb_req_valid_i = 0;
      step();
      itlb_vpn_i = 20'h0BBBB; dtlb_vpn_i = 20'h0CCCC;
      itlb_req_valid_i = 1; dtlb_req_valid_i = 1; rst_i = 1;
      repeat (3) step();
      rst_i = 0;
      step();
      check("reset_abort_count", abort_cnt - ab0, 0);
      check("reset_resp_count", resp_q.size() - rb, 0);
      if (acc_q.size() > 0)
         check("reset_first_grant", {acc_q[acc_q.size()-1].instr, acc_q[acc_q.size()-1].vpn},
               {1'b0, 20'h0CCCC});
      itlb_req_valid_i = 0; dtlb_req_valid_i = 0;
      step();
      ptw_resp_valid_i = 1; ptw_pte_i = 32'h0CCC_C0CF;
      step();
      ptw_resp_valid_i = 0;
      repeat (2) step();
      check_walk("after_reset", rb, ab0, 0, 1'b0, 32'h0CCC_C0CF, 1'b0, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
